// File: rtl/linebuf_loader.sv
// Purpose : decodes the host command byte stream (NOP/SETADDR/WRITE/FILL) into
//           addressed, auto-incrementing 16-bit writes on the line-buffer RAM port.
// Latency : lb_wr rises on the edge that accepts the final argument byte; FILL then
//           streams one write per clk. Backpressure: at most one byte every 2 clks,
//           and no bytes are taken while a fill is streaming.
// Ports   : clk/nrst             clock, async active-low reset
//           cmd_has_data/cmd_rd_data/cmd_rd   shared command register handshake
//           lb_wr/lb_wr_addr/lb_wr_data       line-buffer write port
//           busy/bad_cmd         command in progress / sticky unknown-opcode flag
module linebuf_loader #(
  parameter int         ADDR_W     = 8,
  parameter logic [7:0] OP_NOP     = 8'h00,
  parameter logic [7:0] OP_SETADDR = 8'h01,
  parameter logic [7:0] OP_WRITE   = 8'h02,
  parameter logic [7:0] OP_FILL    = 8'h03
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_has_data,
  input  logic [7:0]        cmd_rd_data,
  output logic              cmd_rd,
  output logic              lb_wr,
  output logic [ADDR_W-1:0] lb_wr_addr,
  output logic [15:0]       lb_wr_data,
  output logic              busy,
  output logic              bad_cmd
);

  localparam logic [2:0] S_OPCODE = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_CNT    = 3'd2;
  localparam logic [2:0] S_HI     = 3'd3;
  localparam logic [2:0] S_LO     = 3'd4;
  localparam logic [2:0] S_FILL   = 3'd5;

  logic [2:0]        r_state;
  logic              r_is_fill;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_count;
  logic [7:0]        r_hi;
  logic              r_cmd_rd;
  logic              r_lb_wr;
  logic [ADDR_W-1:0] r_lb_wr_addr;
  logic [15:0]       r_lb_wr_data;
  logic              r_busy;
  logic              r_bad_cmd;

  logic              w_accept;
  logic [2:0]        w_state_nxt;
  logic              w_is_fill_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_count_nxt;
  logic [7:0]        w_hi_nxt;
  logic              w_wr_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [15:0]       w_wr_data_nxt;
  logic              w_bad_nxt;

  // r_cmd_rd is high exactly in the cycle after an accept, so it doubles as the
  // hold-off that lets the shared register clear before the next byte is sampled.
  assign w_accept = (r_state != S_FILL) && cmd_has_data && !r_cmd_rd;

  always_comb begin
    w_state_nxt   = r_state;
    w_is_fill_nxt = r_is_fill;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    w_hi_nxt      = r_hi;
    w_wr_nxt      = 1'b0;
    w_wr_addr_nxt = r_lb_wr_addr;
    w_wr_data_nxt = r_lb_wr_data;
    w_bad_nxt     = r_bad_cmd;
    case (r_state)
      S_OPCODE: begin
        if (w_accept) begin
          case (cmd_rd_data)
            OP_NOP:     w_state_nxt = S_OPCODE;
            OP_SETADDR: w_state_nxt = S_ADDR;
            OP_WRITE: begin
              w_state_nxt   = S_HI;
              w_is_fill_nxt = 1'b0;
            end
            OP_FILL: begin
              w_state_nxt   = S_CNT;
              w_is_fill_nxt = 1'b1;
            end
            default:    w_bad_nxt = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (w_accept) begin
          w_addr_nxt  = ADDR_W'(cmd_rd_data);
          w_state_nxt = S_OPCODE;
        end
      end
      S_CNT: begin
        if (w_accept) begin
          w_count_nxt = cmd_rd_data;
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (w_accept) begin
          w_hi_nxt    = cmd_rd_data;
          w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (w_accept) begin
          w_wr_nxt      = 1'b1;
          w_wr_addr_nxt = r_addr;
          w_wr_data_nxt = {r_hi, cmd_rd_data};
          w_addr_nxt    = r_addr + 1'b1;
          if (r_is_fill) begin
            // r_count now counts the writes still owed after this one; N=0 wraps
            // to 255 more, giving 256 in total.
            w_count_nxt = r_count - 8'd1;
            w_state_nxt = (r_count == 8'd1) ? S_OPCODE : S_FILL;
          end else begin
            w_state_nxt = S_OPCODE;
          end
        end
      end
      S_FILL: begin
        // Data register already holds {hi,lo}; only the address moves.
        w_wr_nxt      = 1'b1;
        w_wr_addr_nxt = r_addr;
        w_addr_nxt    = r_addr + 1'b1;
        w_count_nxt   = r_count - 8'd1;
        if (r_count == 8'd1) begin
          w_state_nxt = S_OPCODE;
        end
      end
      default: w_state_nxt = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_OPCODE;
      r_is_fill    <= 1'b0;
      r_addr       <= '0;
      r_count      <= 8'd0;
      r_hi         <= 8'd0;
      r_cmd_rd     <= 1'b0;
      r_lb_wr      <= 1'b0;
      r_lb_wr_addr <= '0;
      r_lb_wr_data <= 16'd0;
      r_busy       <= 1'b0;
      r_bad_cmd    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_fill    <= w_is_fill_nxt;
      r_addr       <= w_addr_nxt;
      r_count      <= w_count_nxt;
      r_hi         <= w_hi_nxt;
      r_cmd_rd     <= w_accept;
      r_lb_wr      <= w_wr_nxt;
      r_lb_wr_addr <= w_wr_addr_nxt;
      r_lb_wr_data <= w_wr_data_nxt;
      // Busy is kept up through the final write cycle so it falls with lb_wr.
      r_busy       <= (w_state_nxt != S_OPCODE) || w_wr_nxt;
      r_bad_cmd    <= w_bad_nxt;
    end
  end

  assign cmd_rd     = r_cmd_rd;
  assign lb_wr      = r_lb_wr;
  assign lb_wr_addr = r_lb_wr_addr;
  assign lb_wr_data = r_lb_wr_data;
  assign busy       = r_busy;
  assign bad_cmd    = r_bad_cmd;

endmodule

// File: tb/tb_linebuf_loader.sv
// Purpose : directed plus randomized bench for linebuf_loader; a byte-stream parser
//           predicts the write list, a host model emulates the shared register.
// Ports   : none (top-level bench).
module tb_linebuf_loader;

  typedef logic [7:0] byteq_t[$];

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_has_data;
  logic [7:0]  cmd_rd_data;
  logic        cmd_rd;
  logic        lb_wr;
  logic [7:0]  lb_wr_addr;
  logic [15:0] lb_wr_data;
  logic        busy;
  logic        bad_cmd;

  always #5 clk = ~clk;

  linebuf_loader #(.ADDR_W(8)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .cmd_has_data (cmd_has_data),
    .cmd_rd_data  (cmd_rd_data),
    .cmd_rd       (cmd_rd),
    .lb_wr        (lb_wr),
    .lb_wr_addr   (lb_wr_addr),
    .lb_wr_data   (lb_wr_data),
    .busy         (busy),
    .bad_cmd      (bad_cmd)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          gaps = 1'b0;
  logic [7:0]  hostq[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          got_cyc[$];
  logic        got_rd[$];
  logic        got_busy[$];
  int          m_addr = 0;
  logic        m_bad = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_host();
    if (hostq.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
      cmd_has_data = 1'b1;
      cmd_rd_data  = hostq[0];
    end else begin
      cmd_has_data = 1'b0;
      cmd_rd_data  = 8'h00;
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, log writes, then let the
  // host register drop a consumed byte and present the next one.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (lb_wr === 1'b1) begin
      got_q.push_back({lb_wr_addr, lb_wr_data});
      got_cyc.push_back(cyc);
      got_rd.push_back(cmd_rd);
      got_busy.push_back(busy);
    end
    if (cmd_rd === 1'b1 && hostq.size() > 0) void'(hostq.pop_front());
    drive_host();
  endtask

  task automatic clear_logs();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    got_rd.delete();
    got_busy.delete();
  endtask

  // Reference: parse the command stream and list every RAM write it implies.
  task automatic model(input byteq_t b);
    int i;
    int n;
    i = 0;
    while (i < b.size()) begin
      case (b[i])
        8'h00: i += 1;
        8'h01: begin
          m_addr = int'(b[i+1]);
          i += 2;
        end
        8'h02: begin
          exp_q.push_back({m_addr[7:0], b[i+1], b[i+2]});
          m_addr = (m_addr + 1) % 256;
          i += 3;
        end
        8'h03: begin
          n = (b[i+1] == 8'h00) ? 256 : int'(b[i+1]);
          for (int k = 0; k < n; k++) begin
            exp_q.push_back({m_addr[7:0], b[i+2], b[i+3]});
            m_addr = (m_addr + 1) % 256;
          end
          i += 4;
        end
        default: begin
          m_bad = 1'b1;
          i += 1;
        end
      endcase
    end
  endtask

  task automatic run(input string tag, input byteq_t b);
    logic done;
    clear_logs();
    model(b);
    foreach (b[k]) hostq.push_back(b[k]);
    drive_host();
    done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (hostq.size() == 0 && busy === 1'b0 && lb_wr === 1'b0 && cmd_rd === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, " completes"}, {31'd0, done}, 32'd1);
    check({tag, " nwrites"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s wr%0d addr_data", tag, k), {8'd0, got_q[k]}, {8'd0, exp_q[k]});
    check({tag, " bad_cmd"}, {31'd0, bad_cmd}, {31'd0, m_bad});
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    hostq.delete();
    drive_host();
    m_addr = 0;
    m_bad  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    byteq_t s;
    byteq_t r;
    logic ok;
    int nc;
    int op;

    nrst = 1'b0;
    cmd_has_data = 1'b0;
    cmd_rd_data  = 8'h00;
    #1;
    check("reset cmd_rd", {31'd0, cmd_rd}, 32'd0);
    check("reset lb_wr", {31'd0, lb_wr}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset bad_cmd", {31'd0, bad_cmd}, 32'd0);
    check("reset addr", {24'd0, lb_wr_addr}, 32'd0);
    check("reset data", {16'd0, lb_wr_data}, 32'd0);
    do_reset();

    // Single write, then the following write lands at the incremented address.
    s = '{8'h01, 8'h10, 8'h02, 8'hAB, 8'hCD};
    run("write", s);
    if (got_rd.size() > 0) check("write cmd_rd with lb_wr", {31'd0, got_rd[0]}, 32'd1);
    s = '{8'h02, 8'h00, 8'h01};
    run("next addr", s);

    // Address wrap across two writes.
    s = '{8'h01, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h02, 8'h56, 8'h78};
    run("wrap", s);

    // Fill of 4 with the register still holding data during the fill.
    s = '{8'h01, 8'h20, 8'h03, 8'h04, 8'hBE, 8'hEF, 8'h00, 8'h00};
    run("fill4", s);
    if (got_q.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        check($sformatf("fill4 back2back %0d", k), got_cyc[k] - got_cyc[0], k);
        check($sformatf("fill4 cmd_rd low %0d", k), {31'd0, got_rd[k]}, 32'd0);
      end
      for (int k = 0; k < 4; k++)
        check($sformatf("fill4 busy %0d", k), {31'd0, got_busy[k]}, 32'd1);
    end

    // Fill with N=0 covers the whole buffer and leaves the address back at 0.
    do_reset();
    s = '{8'h03, 8'h00, 8'h00, 8'h00};
    run("fill256", s);
    if (got_q.size() == 256) check("fill256 span", got_cyc[255] - got_cyc[0], 32'd255);
    s = '{8'h02, 8'h12, 8'h34};
    run("after fill256", s);

    // Unknown opcode sets the sticky flag; the stream keeps decoding.
    do_reset();
    s = '{8'h7F, 8'h00, 8'h02, 8'h11, 8'h22};
    run("badcmd", s);
    s = '{8'h00};
    run("badcmd sticky", s);

    // Reset in the middle of a fill.
    do_reset();
    clear_logs();
    r = '{8'h03, 8'h08, 8'hAA, 8'h55};
    foreach (r[k]) hostq.push_back(r[k]);
    drive_host();
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (got_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("midreset reached 2 writes", {31'd0, ok}, 32'd1);
    #3;
    nrst = 1'b0;
    #1;
    check("midreset lb_wr", {31'd0, lb_wr}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset cmd_rd", {31'd0, cmd_rd}, 32'd0);
    check("midreset addr", {24'd0, lb_wr_addr}, 32'd0);
    check("midreset nwrites", got_q.size(), 32'd2);
    if (got_q.size() >= 2) begin
      check("midreset wr0", {8'd0, got_q[0]}, 32'h00AA55);
      check("midreset wr1", {8'd0, got_q[1]}, 32'h01AA55);
    end
    do_reset();
    s = '{8'h02, 8'h33, 8'h44};
    run("post midreset", s);

    // Randomized command streams with idle gaps on the host side.
    gaps = 1'b1;
    for (int it = 0; it < 30; it++) begin
      s.delete();
      nc = $urandom_range(1, 4);
      for (int c = 0; c < nc; c++) begin
        op = $urandom_range(0, 9);
        if (op == 0) begin
          s.push_back(8'h00);
        end else if (op <= 2) begin
          s.push_back(8'h01);
          s.push_back(8'($urandom_range(0, 255)));
        end else if (op <= 5) begin
          s.push_back(8'h02);
          s.push_back(8'($urandom_range(0, 255)));
          s.push_back(8'($urandom_range(0, 255)));
        end else if (op <= 8) begin
          s.push_back(8'h03);
          s.push_back(($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 6)));
          s.push_back(8'($urandom_range(0, 255)));
          s.push_back(8'($urandom_range(0, 255)));
        end else begin
          s.push_back(8'($urandom_range(4, 255)));
        end
      end
      run($sformatf("rnd%0d", it), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
